// File: rtl/vliw_pkg.sv
// vliw_pkg: shared widths, register constants and bundle slot struct for the operand-fetch stage
package vliw_pkg;
   localparam int XLEN     = 32;
   localparam int REG_BITS = 7;
   localparam int LAT_BITS = 3;
   localparam int NREGS    = 1 << REG_BITS;
   localparam logic [REG_BITS-1:0] ZERO_REG = '0;
   typedef struct packed {
      logic [1:0][REG_BITS-1:0] rs;
      logic [REG_BITS-1:0]      rd;
      logic                     we;
      logic [LAT_BITS-1:0]      lat;
   } slot_t;
endpackage

// File: rtl/vliw_fwd_mux.sv
// vliw_fwd_mux: resolves one source operand from zero reg, ex bus, wb bus or register file
// Ports: rs_i source index; ex_*_i execute forwarding bus; wb_*_i writeback buses;
//        rf_data_i async register-file data; op_o resolved operand.
module vliw_fwd_mux
   import vliw_pkg::*;
#(
   parameter int SLOTS     = 4,
   parameter int ALU_SLOTS = 2
) (
   input  logic [REG_BITS-1:0]                rs_i,
   input  logic [ALU_SLOTS-1:0][REG_BITS-1:0] ex_rd_i,
   input  logic [ALU_SLOTS-1:0]               ex_we_i,
   input  logic [ALU_SLOTS-1:0][XLEN-1:0]     ex_data_i,
   input  logic [SLOTS-1:0][REG_BITS-1:0]     wb_rd_i,
   input  logic [SLOTS-1:0]                   wb_we_i,
   input  logic [SLOTS-1:0][XLEN-1:0]         wb_data_i,
   input  logic [XLEN-1:0]                    rf_data_i,
   output logic [XLEN-1:0]                    op_o
);
   logic            ex_hit, wb_hit;
   logic [XLEN-1:0] ex_val, wb_val;
   // ascending scan lets the highest matching slot overwrite lower ones
   always_comb begin
      ex_hit = 1'b0;
      ex_val = '0;
      wb_hit = 1'b0;
      wb_val = '0;
      for (int i = 0; i < ALU_SLOTS; i++)
         if (ex_we_i[i] && ex_rd_i[i] == rs_i) begin
            ex_hit = 1'b1;
            ex_val = ex_data_i[i];
         end
      for (int i = 0; i < SLOTS; i++)
         if (wb_we_i[i] && wb_rd_i[i] == rs_i) begin
            wb_hit = 1'b1;
            wb_val = wb_data_i[i];
         end
      op_o = (rs_i == ZERO_REG) ? '0 : ex_hit ? ex_val : wb_hit ? wb_val : rf_data_i;
   end
endmodule

// File: rtl/vliw_opfetch.sv
// vliw_opfetch: VLIW operand-fetch/hazard stage producing a registered operand bundle
// Ports: in_* incoming bundle; rf_raddr/rf_rdata register-file read; ex_*/wb_* result buses;
//        stall/flush pipeline control; dec_stall hazard to fetch; out_* registered bundle.
// Build option VLIW_OPF_SCOREBOARD_EN: per-register latency scoreboard with WAW check;
// without it only the registered latency-2 producer is checked (latency >2 is illegal).
module vliw_opfetch
   import vliw_pkg::*;
#(
   parameter int SLOTS     = 4,
   parameter int ALU_SLOTS = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   input  logic [SLOTS-1:0][1:0][REG_BITS-1:0] in_rs,
   input  logic [SLOTS-1:0][REG_BITS-1:0]     in_rd,
   input  logic [SLOTS-1:0]                   in_we,
   input  logic [SLOTS-1:0][LAT_BITS-1:0]     in_lat,
   output logic [SLOTS-1:0][1:0][REG_BITS-1:0] rf_raddr,
   input  logic [SLOTS-1:0][1:0][XLEN-1:0]    rf_rdata,
   input  logic [ALU_SLOTS-1:0][REG_BITS-1:0] ex_rd,
   input  logic [ALU_SLOTS-1:0]               ex_we,
   input  logic [ALU_SLOTS-1:0][XLEN-1:0]     ex_data,
   input  logic [SLOTS-1:0][REG_BITS-1:0]     wb_rd,
   input  logic [SLOTS-1:0]                   wb_we,
   input  logic [SLOTS-1:0][XLEN-1:0]         wb_data,
   input  logic                               stall,
   input  logic                               flush,
   output logic                               dec_stall,
   output logic                               out_valid,
   output logic [SLOTS-1:0][1:0][XLEN-1:0]    out_op,
   output logic [SLOTS-1:0][REG_BITS-1:0]     out_rd,
   output logic [SLOTS-1:0]                   out_we,
   output logic [SLOTS-1:0][LAT_BITS-1:0]     out_lat
);
   slot_t [SLOTS-1:0]                  slot;
   logic  [SLOTS-1:0][1:0][XLEN-1:0]   op;
   logic                               haz, issue;
   logic                               out_valid_q;
   logic  [SLOTS-1:0][1:0][XLEN-1:0]   out_op_q;
   logic  [SLOTS-1:0][REG_BITS-1:0]    out_rd_q;
   logic  [SLOTS-1:0]                  out_we_q;
   logic  [SLOTS-1:0][LAT_BITS-1:0]    out_lat_q;

   always_comb
      for (int i = 0; i < SLOTS; i++)
         slot[i] = {in_rs[i], in_rd[i], in_we[i], in_lat[i]};

   assign rf_raddr  = in_rs;
   assign dec_stall = in_valid & haz;
   assign issue     = in_valid & ~dec_stall & ~stall & ~flush;

   for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      for (genvar k = 0; k < 2; k++) begin : g_op
         vliw_fwd_mux #(.SLOTS(SLOTS), .ALU_SLOTS(ALU_SLOTS)) u_mux (
            .rs_i     (in_rs[s][k]),
            .ex_rd_i  (ex_rd),
            .ex_we_i  (ex_we),
            .ex_data_i(ex_data),
            .wb_rd_i  (wb_rd),
            .wb_we_i  (wb_we),
            .wb_data_i(wb_data),
            .rf_data_i(rf_rdata[s][k]),
            .op_o     (op[s][k])
         );
      end
   end

`ifdef VLIW_OPF_SCOREBOARD_EN
   logic [LAT_BITS-1:0] cnt_q [NREGS];
   logic [LAT_BITS-1:0] cnt_d [NREGS];
   // a new set overrides the decrement; later slots override earlier ones on rd collision
   always_comb begin
      cnt_d = cnt_q;
      if (!stall)
         for (int r = 0; r < NREGS; r++)
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_BITS'(1) : cnt_q[r];
      if (issue)
         for (int i = 0; i < SLOTS; i++)
            if (slot[i].we && slot[i].lat >= LAT_BITS'(2) && slot[i].rd != ZERO_REG)
               cnt_d[slot[i].rd] = slot[i].lat - LAT_BITS'(1);
   end
   always_ff @(posedge clk)
      if (rst)
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      else
         cnt_q <= cnt_d;
   always_comb begin
      haz = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         for (int j = 0; j < 2; j++) haz |= cnt_q[slot[i].rs[j]] != '0;
         haz |= slot[i].we && cnt_q[slot[i].rd] != '0;
      end
   end
`else
   // the only unresolved producer is a latency-2 one sitting in the output register
   always_comb begin
      haz = 1'b0;
      for (int i = 0; i < SLOTS; i++)
         for (int j = 0; j < 2; j++)
            for (int m = 0; m < SLOTS; m++)
               haz |= out_valid_q && out_we_q[m] && out_lat_q[m] >= LAT_BITS'(2) &&
                      out_rd_q[m] == slot[i].rs[j] && slot[i].rs[j] != ZERO_REG;
   end
   always_ff @(posedge clk)
      if (!rst && issue)
         for (int i = 0; i < SLOTS; i++)
            assert (!slot[i].we || slot[i].lat <= LAT_BITS'(2));
`endif

   always_ff @(posedge clk)
      if (rst || flush || (dec_stall && !stall)) begin
         out_valid_q <= 1'b0;
         out_op_q    <= '0;
         out_rd_q    <= '0;
         out_we_q    <= '0;
         out_lat_q   <= '0;
      end else if (!stall) begin
         out_valid_q <= in_valid;
         out_op_q    <= op;
         out_rd_q    <= in_rd;
         out_we_q    <= in_we;
         out_lat_q   <= in_lat;
      end

   assign out_valid = out_valid_q;
   assign out_op    = out_op_q;
   assign out_rd    = out_rd_q;
   assign out_we    = out_we_q;
   assign out_lat   = out_lat_q;
endmodule

// File: doc/vliw_opfetch.md
# vliw_opfetch

Parametrised operand-fetch and hazard stage for the VLIW core: sits between fetch and execute and serves an N-slot bundle. It resolves every source operand from the execute forwarding bus, the writeback buses or the register file. A per-register scoreboard stalls consumers of variable-latency producers (loads, multicycle FPU) and replaces the fixed one-bubble load-use rule. Output is a registered, valid-qualified operand bundle for execute.

## Interface
- SLOTS, 4: issue slots per bundle.
- ALU_SLOTS, 2: slots 0..ALU_SLOTS-1 drive the execute-stage forwarding bus.
- XLEN, 32: operand width.
- REG_BITS, 7: register index width; MSB=1 means float register.
- LAT_BITS, 3: latency field width; max latency 2^LAT_BITS-1.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- in_valid  in  1  bundle present.
- in_rs  in  SLOTS×2×REG_BITS  source indices.
- in_rd  in  SLOTS×REG_BITS  destination index.
- in_we  in  SLOTS  slot writes in_rd.
- in_lat  in  SLOTS×LAT_BITS  producer latency, >=1.
- rf_raddr  out  SLOTS×2×REG_BITS  register-file read address, equal to in_rs (comb).
- rf_rdata  in  SLOTS×2×XLEN  async register-file data.
- ex_rd / ex_we / ex_data  in  ALU_SLOTS×(REG_BITS/1/XLEN)  execute results, current cycle.
- wb_rd / wb_we / wb_data  in  SLOTS×(REG_BITS/1/XLEN)  writeback results.
- stall  in  1  downstream freeze.
- flush  in  1  kill bundle in this stage.
- dec_stall  out  1  hazard; upstream holds in_* (comb).
- out_valid  out  1  bundle valid.
- out_op  out  SLOTS×2×XLEN  resolved operands.
- out_rd / out_we / out_lat  out  registered copies.

## Operation
- Source select, per operand, priority order:
  - Index 0 returns 0.
  - Otherwise ex match (ex_we, ex_rd==rs).
  - Otherwise wb match.
  - Otherwise rf_rdata.
- Within a bus, the highest matching slot wins.
- Float register 64 (MSB set, low bits 0) is a real register, not zero.
- Scoreboard: one cnt[r] of LAT_BITS per register; register 0 is never tracked.
- Issue = in_valid & ~dec_stall & ~stall & ~flush.
  - On issue, every slot with in_we and in_lat>=2 sets cnt[in_rd] <= in_lat-1.
  - If slots collide on the same rd, the highest slot wins.
- While ~stall, every nonzero cnt not being set this cycle decrements by 1.
- Contract: a latency-L producer (L>=2) drives wb in cycle L after issue. Latency-1 producers drive ex in cycle 1 and wb in cycle 2.
- dec_stall = in_valid & (any used rs has cnt!=0 (RAW) | any in_we slot's rd has cnt!=0 (WAW)).
- Output register update:
  - rst: all outputs 0.
  - Else flush, or dec_stall & ~stall: out_valid=0, others 0.
  - Else ~stall: capture in_valid and the resolved data.
  - Else hold.
- flush does not clear the scoreboard; in-flight producers are older than the killed bundle.

## Timing
- Operand resolve is combinational. Output is registered with 1-cycle latency.
- Load (L=2) followed by a consumer: exactly one bubble, then data is taken from wb.
- L=5: consumer stalls 4 cycles.
- stall freezes counters, outputs and dec_stall's effect on the outputs.
- Reset mid-operation clears all cnt; in-flight results are discarded by the pipeline.

## Configuration
- VLIW_OPF_SCOREBOARD_EN defined: scoreboard as above, arbitrary latency, WAW check.
- Undefined: no cnt array. dec_stall = rs matches a registered out_rd with out_we & out_lat>=2 & out_valid. Latencies >2 are illegal, checked by assertion.

## Structure
- vliw_pkg holds XLEN, REG_BITS, LAT_BITS, the bundle slot struct (rs, rd, we, lat) and ZERO_REG.
- Sub-module vliw_fwd_mux: one instance per operand, implementing the priority select. The top level holds the scoreboard and output registers.

## Test plan
- Slot0 writes r5=0x10 on the ex bus; next bundle reads r5 in slot3 -> out_op=0x10, no stall.
- Load r7 (lat 2); next bundle reads r7 -> 1 bubble (out_valid=0), then operand = wb_data 0xDEAD.
- FPU f3 lat 5; consumer of f3 -> dec_stall for 4 cycles, issues in cycle 5 with wb value; with stall asserted 2 cycles mid-wait, total wait is 6 cycles.
- Slots 0 and 1 both on ex bus with rd=r9 (0x1, 0x2) -> consumer gets 0x2. Read r0 while ex writes r0=0xFF -> 0.
- Pending cnt on f4; new lat-1 bundle writes f4 -> WAW stall until cnt=0.
- flush during a RAW stall -> out_valid=0, cnt still decrements; rst -> all outputs and cnt 0.
